// File: rtl/tone_seq_pkg.sv
// Shared types and constants for the tone sequencer.
package tone_seq_pkg;

   // Default system clock rate in Hz.
   localparam int CLK_FREQ_DEF = 125000000;

   // Highest legal frequency in centi-Hz (9999.99 Hz).
   localparam logic [31:0] FREQ_MAX = 32'd999999;

   // Playback states; ADVANCE is folded into the FETCH/PLAY/GAP exits.
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_PLAY  = 3'd2,
      S_GAP   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   // One note-table entry: 49 bits.
   typedef struct packed {
      logic [31:0] freq;
      logic [15:0] dur;
      logic        last;
   } note_t;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 1 ms tick generator that can be re-phased with clear_i.
module tick_prescaler #(
   parameter int CLK_FREQ = 125000000,
   parameter int TICK_HZ  = 1000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   output logic tick_o
);

   localparam int TICK_CYC = CLK_FREQ / TICK_HZ;
   localparam int CW       = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   // Tick on the last count of each period; clear forces the period to restart.
   always_comb begin
      tick_o = !clear_i && (cnt_q == CW'(TICK_CYC - 1));
      cnt_d  = (clear_i || tick_o) ? '0 : cnt_q + 1'b1;
   end

   // Count register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/tone_sequencer.sv
// Walks a small note table and drives freq/tone_en to the tone generator.
// Each played note holds for dur ticks, followed by a GAP_MS silent gap;
// zero-duration entries are skipped in a single FETCH cycle.
module tone_sequencer
   import tone_seq_pkg::*;
#(
   parameter int CLK_FREQ   = CLK_FREQ_DEF,
   parameter int TICK_HZ    = 1000,
   parameter int NOTE_DEPTH = 16,
   parameter int GAP_MS     = 10,
   localparam int IW        = $clog2(NOTE_DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   input  logic          repeat_en,
   input  logic          load_en,
   input  logic [IW-1:0] load_addr,
   input  logic [31:0]   load_freq,
   input  logic [15:0]   load_dur,
   input  logic          load_last,
   output logic [31:0]   freq,
   output logic          tone_en,
   output logic          busy,
   output logic          done,
   output logic [IW-1:0] note_idx,
   output logic          err,
   output state_t        dbg_state
);

   state_t        state_q;
   note_t         table_q [NOTE_DEPTH];
   note_t         cur;
   logic [31:0]   freq_q;
   logic          tone_en_q, busy_q, done_q, err_q, rep_q, last_q;
   logic [IW-1:0] idx_q;
   logic [15:0]   dcnt_q;
   logic          tick, load_ok, adv, adv_last, at_end;

   // Prescaler only runs while timing a note or gap, so it is zero at PLAY entry.
   tick_prescaler #(.CLK_FREQ(CLK_FREQ), .TICK_HZ(TICK_HZ)) u_tick (
      .clk_i   (clk),
      .rst_ni  (rst),
      .clear_i ((state_q != S_PLAY) && (state_q != S_GAP)),
      .tick_o  (tick)
   );

   // Entry decode and the folded ADVANCE decision.
   always_comb begin
      cur      = table_q[idx_q];
      load_ok  = load_en && (state_q == S_IDLE) && (load_freq <= FREQ_MAX);
      adv_last = (state_q == S_FETCH) ? cur.last : last_q;
      at_end   = adv_last || (idx_q == IW'(NOTE_DEPTH - 1));
      adv      = ((state_q == S_FETCH) && (cur.dur == 16'd0)) ||
                 ((state_q == S_PLAY) && tick && (dcnt_q == 16'd1) && (GAP_MS == 0)) ||
                 ((state_q == S_GAP) && tick && (dcnt_q == 16'd1));
   end

   // Note table: written only by accepted loads.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NOTE_DEPTH; i++) table_q[i] <= '0;
      end else if (load_ok) begin
         table_q[load_addr] <= '{freq: load_freq, dur: load_dur, last: load_last};
      end
   end

   // Playback FSM with registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         freq_q    <= '0;
         tone_en_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         rep_q     <= 1'b0;
         last_q    <= 1'b0;
         idx_q     <= '0;
         dcnt_q    <= '0;
      end else begin
         done_q <= 1'b0;
         err_q  <= load_en && !load_ok;
         if (abort && (state_q != S_IDLE)) begin
            state_q   <= S_IDLE;
            freq_q    <= '0;
            tone_en_q <= 1'b0;
            busy_q    <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (start && !abort) begin
                     state_q <= S_FETCH;
                     busy_q  <= 1'b1;
                     idx_q   <= '0;
                     rep_q   <= repeat_en;
                  end
               end
               S_FETCH: begin
                  last_q <= cur.last;
                  if (cur.dur != 16'd0) begin
                     state_q   <= S_PLAY;
                     freq_q    <= cur.freq;
                     tone_en_q <= 1'b1;
                     dcnt_q    <= cur.dur;
                  end
               end
               S_PLAY: begin
                  if (tick) begin
                     if (dcnt_q == 16'd1) begin
                        freq_q    <= '0;
                        tone_en_q <= 1'b0;
                        state_q   <= S_GAP;
                        dcnt_q    <= 16'(GAP_MS);
                     end else begin
                        dcnt_q <= dcnt_q - 16'd1;
                     end
                  end
               end
               S_GAP: begin
                  if (tick) dcnt_q <= dcnt_q - 16'd1;
               end
               S_DONE: begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
               default: state_q <= S_IDLE;
            endcase
            // ADVANCE overrides the per-state next state chosen above.
            if (adv) begin
               if (at_end && !rep_q) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end else begin
                  state_q <= S_FETCH;
                  idx_q   <= at_end ? '0 : idx_q + 1'b1;
               end
            end
         end
      end
   end

   assign freq      = freq_q;
   assign tone_en   = tone_en_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign note_idx  = idx_q;
   assign err       = err_q;
   assign dbg_state = state_q;

endmodule

// File: doc/tone_sequencer.md
# tone_sequencer

- Plays a short melody by driving `freq`/`tone_en` into the square-wave tone generator directly downstream.
- Holds a small register-file note table: frequency in centi-Hz, duration in ms, end-of-melody flag.
- On `start` it walks the table: each note is held for its exact duration, followed by a fixed silent articulation gap.
- Software loads the table while the block is idle; busy/done status returns to the control register block.

## Interface
Parameters:
- CLK_FREQ, 125000000, system clock in Hz
- TICK_HZ, 1000, duration unit rate (1 ms); TICK_CYC = CLK_FREQ/TICK_HZ = 125000 cycles
- NOTE_DEPTH, 16, table entries (power of two); IW = log2(NOTE_DEPTH)
- GAP_MS, 10, silent gap after every played note, in ticks

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  125 MHz system clock
  - rst  in  1  asynchronous, active-low reset
- Control:
  - start  in  1  single-cycle request to begin playback at entry 0
  - abort  in  1  stop playback immediately
  - repeat_en  in  1  sampled on accepted start; 1 = loop melody forever
- Table load:
  - load_en  in  1  write one table entry this cycle
  - load_addr  in  IW  entry index
  - load_freq  in  32  centi-Hz, legal 0..999999 (32'd987654 = 9876.54 Hz)
  - load_dur  in  16  note length in ms; 0 = skip entry
  - load_last  in  1  entry ends the melody
- Outputs:
  - freq  out  32  frequency to tone generator; 0 when silent
  - tone_en  out  1  1 while a note sounds
  - busy  out  1  playback in progress
  - done  out  1  one-cycle pulse at normal melody completion
  - note_idx  out  IW  entry currently fetched/playing
  - err  out  1  one-cycle pulse on rejected load

## Operation
- States:
  - IDLE: waits for `start`.
  - FETCH: 1 cycle; reads entry `note_idx`.
    - dur≠0 → PLAY.
    - dur=0 → ADVANCE.
  - PLAY: for dur×TICK_CYC cycles.
    - freq = entry freq, tone_en=1.
    - Then → GAP.
  - GAP: for GAP_MS×TICK_CYC cycles, freq=0, tone_en=0; then → ADVANCE.
  - ADVANCE: 0-cycle decision folded into the GAP/FETCH exit.
    - If entry.last or note_idx==NOTE_DEPTH-1:
      - repeat latched → note_idx=0, FETCH.
      - otherwise → DONE.
    - Else note_idx+1 → FETCH.
  - DONE: 1 cycle, done=1, busy=1; → IDLE.
- Tick prescaler counts 0..TICK_CYC-1; it is cleared on every FETCH exit so durations are cycle-exact.
- Duration counter is 16 bits and counts down from dur to 0 on ticks.
- Loads:
  - Accepted only in IDLE; written next edge.
  - While busy, or with load_freq>999999 → no write, err pulses the cycle after.
- Start while busy: ignored. Start with load_en in IDLE: the load is written, and playback sees the new entry.
- Abort in any non-IDLE state → IDLE next edge; no done pulse; freq=0, tone_en=0. Abort and start in the same IDLE cycle: abort wins.
- Reset values:
  - All table entries {0,0,0}.
  - State IDLE; freq=0, tone_en=0, busy=0, done=0, err=0, note_idx=0.
  - Prescaler and counters 0.
- An all-zero table plays 16 skips, then DONE.

## Timing
- Start accepted at edge t: busy=1 and state FETCH after t; PLAY outputs valid after t+1.
- Note of dur D occupies exactly D×125000 cycles; gap exactly GAP_MS×125000.
- Skipped entry costs 1 cycle (FETCH only), with no gap.
- freq changes only on a PLAY entry/exit edge and is glitch-free/stable for the whole note. tone_en is registered alongside freq.
- busy falls on the edge after DONE (together with done deasserting).
- Abort: outputs silent on the edge after abort sampled.

## Structure
- Package `tone_seq_pkg`:
  - State enum.
  - Note-entry struct {freq[31:0], dur[15:0], last}.
  - FREQ_MAX = 999999.
  - Shared CLK_FREQ default.
- Sub-module `tick_prescaler` (CLK_FREQ, TICK_HZ; clear input, tick output).
- Table: a flop array in the top module, NOTE_DEPTH×49 bits.

## Test plan
- Load entry0 {44000, 2, 0}, entry1 {88000, 1, 1}; GAP_MS=1; start.
  - freq=44000 for 250000 cycles.
  - 0 for 125000.
  - 88000 for 125000.
  - 0 for 125000.
  - done pulse, busy drops next cycle.
- Entry0 dur=0, entry1 {100000, 1, 1}: the FETCH of entry1 follows the FETCH of entry0 by exactly 1 cycle, with no gap.
- repeat_en=1, two-entry melody: note_idx wraps 1→0; no done after 3 loops; abort mid-PLAY → freq=0 next cycle, busy=0, done never seen.
- load_freq=1000000 in IDLE → err pulse, entry unchanged; valid load while busy → err pulse, table unchanged after playback.
- Reset asserted mid-PLAY → all outputs and table zero asynchronously; start after release plays 16 skips and then done.
- Simultaneous start+abort in IDLE → stays IDLE, busy=0.
